systolic_spi_wrapper: RTL and testbench

SPI-slave front end wrapping a 2x2 output-stationary systolic matrix multiplier (C = A x B).
- An external host loads 8-bit A and B operands, starts a compute, and reads back four 32-bit results as little-endian bytes.
- Every SPI byte is its own cs_n frame. Controller state persists across frames.
- irq signals compute completion to the host.

---
 rtl/systolic_spi_wrapper_if.sv | 13 +
 rtl/systolic_spi_wrapper.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_systolic_spi_wrapper.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_spi_wrapper_if.sv
// SPI pin bundle between an external host (master) and the systolic wrapper (slave).
// Latency: none, wires only.
// Backpressure: none; the SPI host owns all pin timing.
interface systolic_spi_wrapper_if;
   logic sclk;
   logic mosi;
   logic cs_n;
   logic miso;
   logic irq;

   modport master (output sclk, output mosi, output cs_n, input miso, input irq);
   modport slave  (input sclk, input mosi, input cs_n, output miso, output irq);
endinterface

// File: rtl/systolic_spi_wrapper.sv
// SPI-slave front end around a 2x2 output-stationary systolic multiplier (C = A x B).
// Latency: byte visible 3 clk after its 8th sclk rise; results and irq 6 clk after COMPUTE entry.
// Backpressure: none; bytes arriving during COMPUTE are dropped. Macro SIGNED_MULT_EN selects signed operands.

// 2x2 output-stationary array: A flows right, B flows down, each PE keeps its own sum.
module systolic_array #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int N      = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr_i,
   input  logic                      en_i,
   input  logic [N-1:0][DATA_W-1:0]  a_edge_i,
   input  logic [N-1:0][DATA_W-1:0]  b_edge_i,
   output logic [N*N-1:0][ACC_W-1:0] c_o
);
   logic [DATA_W-1:0]        a_p00_q, a_p10_q, b_p00_q, b_p01_q;
   logic [N*N-1:0][ACC_W-1:0] acc_q;

   // Operand extension to accumulator width; wrap-around modulo 2^ACC_W is intended.
   function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
`ifdef SIGNED_MULT_EN
      return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
`else
      return {{(ACC_W-DATA_W){1'b0}}, v};
`endif
   endfunction

   function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] acc,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
      return acc + ext(a) * ext(b);
   endfunction

   // PE pipeline and accumulators; index 0=PE00, 1=PE01, 2=PE10, 3=PE11.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_p00_q <= '0;
         a_p10_q <= '0;
         b_p00_q <= '0;
         b_p01_q <= '0;
         acc_q   <= '0;
      end else if (clr_i) begin
         a_p00_q <= '0;
         a_p10_q <= '0;
         b_p00_q <= '0;
         b_p01_q <= '0;
         acc_q   <= '0;
      end else if (en_i) begin
         acc_q[0] <= mac(acc_q[0], a_edge_i[0], b_edge_i[0]);
         acc_q[1] <= mac(acc_q[1], a_p00_q,     b_edge_i[1]);
         acc_q[2] <= mac(acc_q[2], a_edge_i[1], b_p00_q);
         acc_q[3] <= mac(acc_q[3], a_p10_q,     b_p01_q);
         a_p00_q  <= a_edge_i[0];
         a_p10_q  <= a_edge_i[1];
         b_p00_q  <= b_edge_i[0];
         b_p01_q  <= b_edge_i[1];
      end
   end

   assign c_o = acc_q;
endmodule

// Command controller: operand loading, compute sequencing, result readback.
module systolic_spi_ctrl #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int N      = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_vld_i,
   input  logic [7:0]                rx_dat_i,
   input  logic [N*N-1:0][ACC_W-1:0] c_i,
   output logic [7:0]                spi_tx_data,
   output logic                      spi_tx_ready,
   output logic                      irq_o,
   output logic                      arr_clr_o,
   output logic                      arr_en_o,
   output logic [N-1:0][DATA_W-1:0]  a_edge_o,
   output logic [N-1:0][DATA_W-1:0]  b_edge_o
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_A  = 3'd2;
   localparam logic [2:0] S_LOAD_B  = 3'd3;
   localparam logic [2:0] S_COMPUTE = 3'd4;
   localparam logic [2:0] S_READ    = 3'd5;
   localparam logic [2:0] LAST_STEP = 3'(2*N+1);

   logic [2:0]                 state, state_d;
   logic [1:0]                 element_index, byte_index;
   logic [N*N-1:0][DATA_W-1:0] a_q, b_q;
   logic [ACC_W-1:0]           results_storage [N*N];
   logic                       irq_q;
   logic [2:0]                 cnt_q;

   logic idle_rx, cmd_load_a, cmd_load_b, cmd_compute, cmd_read, done;

   assign idle_rx     = (state == S_IDLE) && rx_vld_i;
   assign cmd_load_a  = idle_rx && (rx_dat_i == 8'h10);
   assign cmd_load_b  = idle_rx && (rx_dat_i == 8'h20);
   assign cmd_compute = idle_rx && (rx_dat_i == 8'h30);
   assign cmd_read    = idle_rx && (rx_dat_i == 8'h40);
   assign done        = (state == S_COMPUTE) && (cnt_q == LAST_STEP);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE: begin
            if (cmd_load_a)       state_d = S_LOAD_A;
            else if (cmd_load_b)  state_d = S_LOAD_B;
            else if (cmd_compute) state_d = S_COMPUTE;
            else if (cmd_read)    state_d = S_READ;
         end
         S_LOAD_A, S_LOAD_B: begin
            if (rx_vld_i && element_index == 2'd3) state_d = S_IDLE;
         end
         S_COMPUTE: begin
            if (done) state_d = S_IDLE;
         end
         S_READ: begin
            if (rx_vld_i && element_index == 2'd3 && byte_index == 2'd3) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: tx byte, array control and skewed operand feed (row i delayed i, column j delayed j).
   always_comb begin
      spi_tx_ready = 1'b0;
      spi_tx_data  = 8'h00;
      arr_en_o     = 1'b0;
      a_edge_o     = '0;
      b_edge_o     = '0;
      arr_clr_o    = cmd_compute;
      case (state)
         S_COMPUTE: begin
            arr_en_o = !done;
            case (cnt_q)
               3'd0: begin
                  a_edge_o[0] = a_q[0];
                  b_edge_o[0] = b_q[0];
               end
               3'd1: begin
                  a_edge_o[0] = a_q[1];
                  a_edge_o[1] = a_q[2];
                  b_edge_o[0] = b_q[2];
                  b_edge_o[1] = b_q[1];
               end
               3'd2: begin
                  a_edge_o[1] = a_q[3];
                  b_edge_o[1] = b_q[3];
               end
               default: ;
            endcase
         end
         S_READ: begin
            spi_tx_ready = 1'b1;
            spi_tx_data  = results_storage[element_index][{byte_index, 3'b000} +: 8];
         end
         default: ;
      endcase
   end

   // Indices, operand stores, compute counter, result capture and irq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         element_index   <= '0;
         byte_index      <= '0;
         a_q             <= '0;
         b_q             <= '0;
         results_storage <= '{default: '0};
         irq_q           <= 1'b0;
         cnt_q           <= '0;
      end else begin
         if (cmd_load_a || cmd_load_b || cmd_read)
            element_index <= '0;
         else if ((state == S_LOAD_A || state == S_LOAD_B) && rx_vld_i)
            element_index <= element_index + 2'd1;
         else if (state == S_READ && rx_vld_i && byte_index == 2'd3)
            element_index <= element_index + 2'd1;

         if (cmd_read)
            byte_index <= '0;
         else if (state == S_READ && rx_vld_i)
            byte_index <= byte_index + 2'd1;

         if (state == S_LOAD_A && rx_vld_i) a_q[element_index] <= rx_dat_i;
         if (state == S_LOAD_B && rx_vld_i) b_q[element_index] <= rx_dat_i;

         if (cmd_compute)   cnt_q <= '0;
         else if (arr_en_o) cnt_q <= cnt_q + 3'd1;

         if (done) begin
            results_storage[0] <= c_i[0];
            results_storage[1] <= c_i[1];
            results_storage[2] <= c_i[2];
            results_storage[3] <= c_i[3];
            irq_q <= 1'b1;
         end else if (cmd_read) begin
            irq_q <= 1'b0;
         end
      end
   end

   assign irq_o = irq_q;
endmodule

module systolic_spi_wrapper #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int N      = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   systolic_spi_wrapper_if.slave spi
);
   logic [2:0] sclk_sync_q, cs_sync_q;
   logic [1:0] mosi_sync_q;
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
   logic       frame_q, rx_vld_q;
   logic [2:0] bit_cnt_q;
   logic [6:0] rx_shift_q;
   logic [7:0] tx_shift_q, rx_dat_q, tx_load;

   logic [7:0]                 spi_tx_data;
   logic                       spi_tx_ready, irq, arr_clr, arr_en;
   logic [N-1:0][DATA_W-1:0]   a_edge, b_edge;
   logic [N*N-1:0][ACC_W-1:0]  arr_c;
   logic [ACC_W-1:0]           sys_results_00;

   // Two-flop synchronisers plus one history flop for edge detection; cs_n idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b00;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
         cs_sync_q   <= {cs_sync_q[1:0], spi.cs_n};
         mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
      end
   end

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign mosi_s    = mosi_sync_q[1];
   assign tx_load   = spi_tx_ready ? spi_tx_data : 8'h00;

   // Byte framing: load tx on cs_n fall, shift in on rise, shift out on fall, drop partial bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q    <= 1'b0;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         rx_vld_q   <= 1'b0;
         rx_dat_q   <= '0;
      end else begin
         rx_vld_q <= 1'b0;
         if (cs_rise) begin
            frame_q <= 1'b0;
         end else if (cs_fall) begin
            frame_q    <= 1'b1;
            bit_cnt_q  <= '0;
            tx_shift_q <= tx_load;
         end else if (frame_q) begin
            if (sclk_rise) begin
               rx_shift_q <= {rx_shift_q[5:0], mosi_s};
               bit_cnt_q  <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_vld_q <= 1'b1;
                  rx_dat_q <= {rx_shift_q, mosi_s};
               end
            end else if (sclk_fall) begin
               tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end
         end
      end
   end

   assign spi.miso = frame_q & tx_shift_q[7];
   assign spi.irq  = irq;
   assign sys_results_00 = arr_c[0];

   systolic_spi_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N(N)) spi_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_vld_i     (rx_vld_q),
      .rx_dat_i     (rx_dat_q),
      .c_i          ({arr_c[N*N-1:1], sys_results_00}),
      .spi_tx_data  (spi_tx_data),
      .spi_tx_ready (spi_tx_ready),
      .irq_o        (irq),
      .arr_clr_o    (arr_clr),
      .arr_en_o     (arr_en),
      .a_edge_o     (a_edge),
      .b_edge_o     (b_edge)
   );

   systolic_array #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N(N)) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (arr_clr),
      .en_i     (arr_en),
      .a_edge_i (a_edge),
      .b_edge_i (b_edge),
      .c_o      (arr_c)
   );
endmodule

// File: tb/tb_systolic_spi_wrapper.sv
// Bench for systolic_spi_wrapper: SPI host driving load/compute/read commands.
// Checks readback against a matrix-product reference model kept here.
// Also covers reset state, partial frames, unknown commands and reset mid-read.
module tb_systolic_spi_wrapper;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   systolic_spi_wrapper_if spi_if ();
   systolic_spi_wrapper dut (.clk(clk), .rst_n(rst_n), .spi(spi_if));

   int total = 0;
   int bad   = 0;

   logic [7:0]  ma [4];
   logic [7:0]  mb [4];
   logic [31:0] mres [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ext(input logic [7:0] v);
`ifdef SIGNED_MULT_EN
      return {{24{v[7]}}, v};
`else
      return {24'd0, v};
`endif
   endfunction

   // Plain matrix product, modulo 2^32.
   function automatic void model_compute();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            logic [31:0] acc;
            acc = 32'd0;
            for (int k = 0; k < 2; k++) acc = acc + ext(ma[i*2+k]) * ext(mb[k*2+j]);
            mres[i*2+j] = acc;
         end
   endfunction

   // One byte frame, mode 0; starts and ends on a clk falling edge.
   task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
      spi_if.cs_n = 1'b0;
      #100;
      for (int b = 7; b >= 0; b--) begin
         spi_if.mosi = tx[b];
         #50;
         rx[b] = spi_if.miso;
         spi_if.sclk = 1'b1;
         #50;
         spi_if.sclk = 1'b0;
      end
      #50;
      spi_if.cs_n = 1'b1;
      spi_if.mosi = 1'b0;
      #100;
   endtask

   task automatic spi_partial(input logic [7:0] tx, input int nbits);
      spi_if.cs_n = 1'b0;
      #100;
      for (int i = 0; i < nbits; i++) begin
         spi_if.mosi = tx[7-i];
         #50;
         spi_if.sclk = 1'b1;
         #50;
         spi_if.sclk = 1'b0;
      end
      #50;
      spi_if.cs_n = 1'b1;
      #100;
   endtask

   task automatic load(input string tag, input logic [7:0] cmd, input logic [31:0] vals);
      logic [7:0] rx;
      spi_xfer(cmd, rx);
      chk({tag, "_cmd_miso"}, 32'(rx), 32'h0);
      chk({tag, "_state"}, 32'(dut.spi_ctrl.state), (cmd == 8'h10) ? 32'd2 : 32'd3);
      for (int i = 0; i < 4; i++) begin
         spi_xfer(vals[8*i +: 8], rx);
         if (cmd == 8'h10) ma[i] = vals[8*i +: 8];
         else              mb[i] = vals[8*i +: 8];
      end
      chk({tag, "_state_after"}, 32'(dut.spi_ctrl.state), 32'd0);
   endtask

   task automatic compute(input string tag);
      logic [7:0] rx;
      chk({tag, "_irq_before"}, 32'(spi_if.irq), 32'd0);
      model_compute();
      spi_xfer(8'h30, rx);
      for (int i = 0; i < 40; i++) begin
         if (spi_if.irq === 1'b1) break;
         @(negedge clk);
      end
      chk({tag, "_irq_set"}, 32'(spi_if.irq), 32'd1);
      chk({tag, "_state_idle"}, 32'(dut.spi_ctrl.state), 32'd0);
      chk({tag, "_c00"}, dut.sys_results_00, mres[0]);
   endtask

   task automatic read_back(input string tag);
      logic [7:0] rx;
      spi_xfer(8'h40, rx);
      chk({tag, "_irq_clr"}, 32'(spi_if.irq), 32'd0);
      chk({tag, "_state_read"}, 32'(dut.spi_ctrl.state), 32'd5);
      for (int e = 0; e < 4; e++) begin
         for (int b = 0; b < 4; b++) begin
            spi_xfer(8'h00, rx);
            chk($sformatf("%s_e%0d_b%0d", tag, e, b), 32'(rx), 32'(mres[e][8*b +: 8]));
         end
         if (e == 0) begin
            chk({tag, "_eidx1"}, 32'(dut.spi_ctrl.element_index), 32'd1);
            chk({tag, "_bidx0"}, 32'(dut.spi_ctrl.byte_index), 32'd0);
            chk({tag, "_state_mid"}, 32'(dut.spi_ctrl.state), 32'd5);
         end
      end
      chk({tag, "_state_end"}, 32'(dut.spi_ctrl.state), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0]  rx;
      logic [31:0] va, vb;

      rst_n = 1'b0;
      spi_if.sclk = 1'b0;
      spi_if.mosi = 1'b0;
      spi_if.cs_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1000;

      // Reset state
      chk("rst_c00", dut.sys_results_00, 32'd0);
      chk("rst_res0", dut.spi_ctrl.results_storage[0], 32'd0);
      chk("rst_irq", 32'(spi_if.irq), 32'd0);
      chk("rst_state", 32'(dut.spi_ctrl.state), 32'd0);
      chk("rst_miso", 32'(spi_if.miso), 32'd0);

      // Unknown commands are ignored
      spi_xfer(8'h55, rx);
      chk("unk55_state", 32'(dut.spi_ctrl.state), 32'd0);
      spi_xfer(8'h00, rx);
      chk("unk00_state", 32'(dut.spi_ctrl.state), 32'd0);

      // Directed small matrices
      load("dirA", 8'h10, 32'h04030201);
      load("dirB", 8'h20, 32'h08070605);
      compute("dir");
      chk("dir_res0", dut.spi_ctrl.results_storage[0], 32'd19);
      chk("dir_res1", dut.spi_ctrl.results_storage[1], 32'd22);
      chk("dir_res2", dut.spi_ctrl.results_storage[2], 32'd43);
      chk("dir_res3", dut.spi_ctrl.results_storage[3], 32'd50);
      read_back("dir");

      // All-ones operands: largest unsigned products
      load("maxA", 8'h10, 32'hFFFFFFFF);
      load("maxB", 8'h20, 32'hFFFFFFFF);
      compute("max");
      read_back("max");

      // Partial frame while loading A is discarded
      spi_xfer(8'h10, rx);
      spi_partial(8'hA5, 3);
      chk("part_eidx0", 32'(dut.spi_ctrl.element_index), 32'd0);
      spi_xfer(8'h07, rx);
      chk("part_eidx1", 32'(dut.spi_ctrl.element_index), 32'd1);
      chk("part_state", 32'(dut.spi_ctrl.state), 32'd2);
      ma[0] = 8'h07;
      for (int i = 1; i < 4; i++) begin
         ma[i] = 8'($urandom_range(0, 255));
         spi_xfer(ma[i], rx);
      end
      chk("part_state_end", 32'(dut.spi_ctrl.state), 32'd0);
      vb = $urandom();
      load("partB", 8'h20, vb);
      compute("part");
      read_back("part");

      // Random operands
      for (int r = 0; r < 2; r++) begin
         va = $urandom();
         vb = $urandom();
         load($sformatf("rnd%0dA", r), 8'h10, va);
         load($sformatf("rnd%0dB", r), 8'h20, vb);
         compute($sformatf("rnd%0d", r));
         read_back($sformatf("rnd%0d", r));
      end

      // Reset mid-read and mid-frame
      va = $urandom() | 32'h01010101;
      vb = $urandom() | 32'h01010101;
      load("rstA", 8'h10, va);
      load("rstB", 8'h20, vb);
      compute("rstc");
      spi_xfer(8'h40, rx);
      spi_xfer(8'h00, rx);
      spi_xfer(8'h00, rx);
      spi_if.cs_n = 1'b0;
      #100;
      spi_if.sclk = 1'b1;
      #50;
      spi_if.sclk = 1'b0;
      #50;
      rst_n = 1'b0;
      #30;
      chk("mid_state", 32'(dut.spi_ctrl.state), 32'd0);
      chk("mid_irq", 32'(spi_if.irq), 32'd0);
      chk("mid_miso", 32'(spi_if.miso), 32'd0);
      for (int k = 0; k < 4; k++)
         chk($sformatf("mid_res%0d", k), dut.spi_ctrl.results_storage[k], 32'd0);
      chk("mid_c00", dut.sys_results_00, 32'd0);
      spi_if.cs_n = 1'b1;
      #50;
      rst_n = 1'b1;
      #200;
      chk("post_state", 32'(dut.spi_ctrl.state), 32'd0);
      chk("post_eidx", 32'(dut.spi_ctrl.element_index), 32'd0);
      chk("post_miso", 32'(spi_if.miso), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
